sh_mem_port_seq: RTL and testbench

//  Per-core access sequencer in front of the shared banked memory.

---
 rtl/sh_mem_port_seq_pkg.sv | 26 ++
 rtl/sh_mem_seq_fifo.sv | 58 +++++
 rtl/sh_mem_port_seq.sv | 155 +++++++++++++++
 tb/tb_sh_mem_port_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sh_mem_port_seq_pkg.sv
// =====================================================================
// Module  : sh_mem_port_seq_pkg
// Purpose : shared state encoding, bus-enable codes and entry sizing
//           for the shared-memory port sequencer.
// Rev     : 1.0
// =====================================================================
`default_nettype none

package sh_mem_port_seq_pkg;

  typedef enum logic [0:0] {
    SEQ_ST_IDLE  = 1'b0,
    SEQ_ST_ISSUE = 1'b1
  } seq_state_t;

  localparam logic [1:0] MEM_EN_RD = 2'b01;
  localparam logic [1:0] MEM_EN_WR = 2'b10;

  // FIFO entry layout is {we, addr, wdata}
  function automatic int entry_width(input int addr_size, input int reg_size);
    return 1 + addr_size + reg_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sh_mem_seq_fifo.sv
// =====================================================================
// Module  : sh_mem_seq_fifo
// Purpose : synchronous request FIFO, wrap-around pointers with an
//           extra MSB to tell full from empty.
// Rev     : 1.0
// =====================================================================
`default_nettype none

module sh_mem_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_aw:0]    w_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign full      = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign one_left  = (w_count == (c_aw+1)'(1));
  assign rd_data   = r_mem[r_rd_ptr[c_aw-1:0]];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/sh_mem_port_seq.sv
// =====================================================================
// Module  : sh_mem_port_seq
// Purpose : per-core sequencer issuing buffered LSU requests one at a
//           time onto the shared banked-memory bus.
// Options : SH_MEM_SEQ_STATS_EN adds stat_reqs / stat_stall counters.
// Rev     : 1.0
// =====================================================================
`default_nettype none

module sh_mem_port_seq
  import sh_mem_port_seq_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int REG_SIZE   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [REG_SIZE-1:0]  req_wdata,
  output logic                 resp_valid,
  output logic                 resp_we,
  output logic [REG_SIZE-1:0]  resp_rdata,
  output logic [1:0]           mem_enable,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [REG_SIZE-1:0]  mem_wr_data,
  input  logic [REG_SIZE-1:0]  mem_rd_data,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 timeout_err
`ifdef SH_MEM_SEQ_STATS_EN
  ,
  output logic [31:0]          stat_reqs,
  output logic [31:0]          stat_stall
`endif
);

  localparam int c_entry_w = entry_width(ADDR_SIZE, REG_SIZE);
  localparam int c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

  seq_state_t           r_state;
  seq_state_t           w_state_next;
  logic [c_entry_w-1:0] w_head;
  logic                 w_head_we;
  logic [ADDR_SIZE-1:0] w_head_addr;
  logic [REG_SIZE-1:0]  w_head_wdata;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_one;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_fire;
  logic [c_cnt_w-1:0]   r_wait_cnt;
  logic [c_cnt_w-1:0]   w_wait_next;
  logic                 r_resp_valid;
  logic                 r_resp_we;
  logic [REG_SIZE-1:0]  r_resp_rdata;
  logic                 r_timeout_err;

  assign req_ready = ~w_full;
  assign w_push    = req_valid & ~w_full;
  assign w_issue   = (r_state == SEQ_ST_ISSUE);
  assign w_fire    = w_issue & mem_ready;
  assign {w_head_we, w_head_addr, w_head_wdata} = w_head;

  sh_mem_seq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_entry_w)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_fire),
    .wr_data  ({req_we, req_addr, req_wdata}),
    .rd_data  (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .one_left (w_one)
  );

  always_comb begin
    w_state_next = r_state;
    mem_enable   = 2'b00;
    mem_addr     = '0;
    mem_wr_data  = '0;
    w_wait_next  = '0;
    case (r_state)
      SEQ_ST_IDLE: begin
        if (!w_empty) w_state_next = SEQ_ST_ISSUE;
      end
      SEQ_ST_ISSUE: begin
        // Dropping enable in the ready cycle keeps the bank from granting twice
        mem_enable  = (w_head_we ? MEM_EN_WR : MEM_EN_RD) & {2{~mem_ready}};
        mem_addr    = w_head_addr;
        mem_wr_data = w_head_wdata;
        if (!mem_ready)
          w_wait_next = (r_wait_cnt == c_timeout) ? c_timeout : r_wait_cnt + 1'b1;
        if (mem_ready && w_one && !w_push) w_state_next = SEQ_ST_IDLE;
      end
      default: w_state_next = SEQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= SEQ_ST_IDLE;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_we     <= 1'b0;
      r_resp_rdata  <= '0;
    end else begin
      r_state      <= w_state_next;
      r_wait_cnt   <= w_wait_next;
      r_resp_valid <= w_fire;
      if (w_wait_next == c_timeout) r_timeout_err <= 1'b1;
      if (w_fire) begin
        r_resp_we    <= w_head_we;
        r_resp_rdata <= w_head_we ? '0 : mem_rd_data;
      end
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_we     = r_resp_we;
  assign resp_rdata  = r_resp_rdata;
  assign timeout_err = r_timeout_err;
  assign busy        = ~w_empty | w_issue;

`ifdef SH_MEM_SEQ_STATS_EN
  logic [31:0] r_stat_reqs;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_reqs  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_fire)                r_stat_reqs  <= r_stat_reqs + 32'd1;
      if (w_issue && !mem_ready) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_reqs  = r_stat_reqs;
  assign stat_stall = r_stat_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sh_mem_port_seq.sv
// =====================================================================
// Module  : tb_sh_mem_port_seq
// Purpose : scoreboard bench for sh_mem_port_seq (directed + random).
// Rev     : 1.0
// =====================================================================
`default_nettype none

module tb_sh_mem_port_seq;

  localparam int AW    = 8;
  localparam int RW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [RW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_we;
  logic [RW-1:0] resp_rdata;
  logic [1:0]    mem_enable;
  logic [AW-1:0] mem_addr;
  logic [RW-1:0] mem_wr_data;
  logic [RW-1:0] mem_rd_data;
  logic          mem_ready;
  logic          busy;
  logic          timeout_err;
`ifdef SH_MEM_SEQ_STATS_EN
  logic [31:0]   stat_reqs;
  logic [31:0]   stat_stall;
`endif

  // memory side: either driven by hand (directed) or by the responder
  logic          auto_en = 1'b0;
  logic          man_ready = 1'b0;
  logic          auto_ready = 1'b0;
  logic [RW-1:0] man_rd = '0;
  logic [RW-1:0] auto_rd = '0;
  assign mem_ready   = auto_en ? auto_ready : man_ready;
  assign mem_rd_data = auto_en ? auto_rd : man_rd;

  always #5 clk = ~clk;

  sh_mem_port_seq #(
    .ADDR_SIZE  (AW),
    .REG_SIZE   (RW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_we     (resp_we),
    .resp_rdata  (resp_rdata),
    .mem_enable  (mem_enable),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .mem_ready   (mem_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
`ifdef SH_MEM_SEQ_STATS_EN
    ,
    .stat_reqs   (stat_reqs),
    .stat_stall  (stat_stall)
`endif
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [RW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic          we;
    logic [RW-1:0] rdata;
  } resp_t;

  req_t  req_q[$];   // accepted, not yet granted
  resp_t exp_q[$];   // granted, response not yet seen
  int    errors = 0;
  int    checks = 0;
  int    fixed_dly = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every response must match the oldest granted request
  resp_t mon_e;
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got resp_valid=1 with no outstanding request (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_we", 64'(resp_we), 64'(mon_e.we));
        chk("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
      end
    end
  end

  // memory responder: grants after a random number of enable cycles
  int    rcnt = 0;
  int    rdly = 1;
  req_t  rsp_h;
  resp_t rsp_e;
  always @(negedge clk) begin
    if (!auto_en || !reset) begin
      auto_ready = 1'b0;
      rcnt = 0;
    end else if (auto_ready) begin
      auto_ready = 1'b0;
    end else if (mem_enable != 2'b00) begin
      if (rcnt >= rdly) begin
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got mem_enable=%b with no request queued", mem_enable);
        end else begin
          rsp_h = req_q.pop_front();
          chk("mem_enable", 64'(mem_enable), rsp_h.we ? 64'h2 : 64'h1);
          chk("mem_addr", 64'(mem_addr), 64'(rsp_h.addr));
          if (rsp_h.we) chk("mem_wr_data", 64'(mem_wr_data), 64'(rsp_h.wdata));
          auto_rd     = RW'($urandom);
          rsp_e.we    = rsp_h.we;
          rsp_e.rdata = rsp_h.we ? '0 : auto_rd;
          exp_q.push_back(rsp_e);
          auto_ready = 1'b1;
        end
        rcnt = 0;
        rdly = (fixed_dly > 0) ? fixed_dly : $urandom_range(1, 4);
      end else begin
        rcnt++;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      auto_ready = 1'b1;   // stray ready while idle must be ignored
      auto_rd    = RW'($urandom);
    end
  end

`ifdef SH_MEM_SEQ_STATS_EN
  int m_reqs = 0;
  int m_stall = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reqs  = 0;
      m_stall = 0;
    end else begin
      if (mem_enable != 2'b00) m_stall++;
      if (resp_valid)          m_reqs++;
    end
  end
`endif

  task automatic drain();
    int g = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0 || busy) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_done", 64'(req_q.size() == 0 && exp_q.size() == 0 && !busy), 64'h1);
  endtask

  task automatic single_access(input logic we, input logic [AW-1:0] a,
                               input logic [RW-1:0] wd, input logic [RW-1:0] rd);
    resp_t e;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    chk("sa_req_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("sa_enable_before_issue", 64'(mem_enable), 64'h0);
    chk("sa_busy_pending", 64'(busy), 64'h1);
    @(posedge clk); #1;
    chk("sa_issue_enable", 64'(mem_enable), we ? 64'h2 : 64'h1);
    chk("sa_issue_addr", 64'(mem_addr), 64'(a));
    if (we) chk("sa_issue_wdata", 64'(mem_wr_data), 64'(wd));
    e.we = we;
    e.rdata = we ? '0 : rd;
    exp_q.push_back(e);
    man_rd = rd; man_ready = 1'b1;
    #1;
    chk("sa_ready_gates_enable", 64'(mem_enable), 64'h0);
    @(posedge clk); #1;
    man_ready = 1'b0;
    chk("sa_resp_valid", 64'(resp_valid), 64'h1);
    chk("sa_enable_after_ready", 64'(mem_enable), 64'h0);
    @(posedge clk); #1;
    chk("sa_resp_one_cycle", 64'(resp_valid), 64'h0);
    chk("sa_idle_busy", 64'(busy), 64'h0);
  endtask

  task automatic fill_test();
    req_t r;
    int acc = 0;
    int guard = 0;
    while (acc < DEPTH && guard < 20) begin
      r.we = 1'b1; r.addr = AW'($urandom); r.wdata = RW'($urandom);
      req_valid = 1'b1; req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
      if (req_ready) begin
        req_q.push_back(r);
        acc++;
      end
      @(posedge clk); #1;
      guard++;
    end
    r.we = 1'b1; r.addr = AW'($urandom); r.wdata = RW'($urandom);
    req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
    chk("full_req_ready", 64'(req_ready), 64'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("full_req_ready_hold", 64'(req_ready), 64'h0);
    end
    fixed_dly = 1;
    auto_en = 1'b1;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("fifth_req_accepted", 64'(req_ready), 64'h1);
    req_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
    auto_en = 1'b0;
    fixed_dly = 0;
  endtask

  task automatic random_phase();
    req_t r;
    auto_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r.we = 1'($urandom); r.addr = AW'($urandom); r.wdata = RW'($urandom);
      req_valid = ($urandom_range(0, 2) != 0);
      req_we = r.we; req_addr = r.addr; req_wdata = r.wdata;
      if (req_valid && req_ready) req_q.push_back(r);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    drain();
    auto_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_enable", 64'(mem_enable), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_timeout_err", 64'(timeout_err), 64'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    single_access(1'b0, 8'h12, 8'h00, 8'hA5);
    single_access(1'b1, 8'h34, 8'h5A, 8'hFF);

    // ready pulse while idle: no response, nothing popped
    man_rd = 8'h77; man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    chk("idle_ready_busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    chk("idle_ready_no_resp", 64'(resp_valid), 64'h0);

    fill_test();
    random_phase();

    // timeout: read held without ready
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("tmo_issue_enable", 64'(mem_enable), 64'h1);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("tmo_before_limit", 64'(timeout_err), 64'h0);
    @(posedge clk); #1;
    chk("tmo_at_limit", 64'(timeout_err), 64'h1);
    begin
      resp_t e;
      e.we = 1'b0; e.rdata = 8'hC3;
      exp_q.push_back(e);
    end
    man_rd = 8'hC3; man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    @(posedge clk); #1;
    chk("tmo_sticky", 64'(timeout_err), 64'h1);
    chk("tmo_done_busy", 64'(busy), 64'h0);

`ifdef SH_MEM_SEQ_STATS_EN
    chk("stat_reqs", 64'(stat_reqs), 64'(m_reqs));
    chk("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif

    // reset asserted mid-ISSUE with a second request still queued
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h55; req_wdata = 8'h66;
    @(posedge clk); #1;
    req_addr = 8'h56;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_mid_issue_enable", 64'(mem_enable), 64'h2);
    reset = 1'b0;
    #1;
    chk("rst_async_enable", 64'(mem_enable), 64'h0);
    chk("rst_async_busy", 64'(busy), 64'h0);
    chk("rst_async_req_ready", 64'(req_ready), 64'h1);
    chk("rst_async_timeout", 64'(timeout_err), 64'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_enable", 64'(mem_enable), 64'h0);
    chk("post_rst_busy", 64'(busy), 64'h0);
`ifdef SH_MEM_SEQ_STATS_EN
    chk("post_rst_stat_reqs", 64'(stat_reqs), 64'h0);
`endif
    chk("final_exp_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
